// File: rtl/divider_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and
// the default operand width.
package divider_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/divider_if.sv
// Request/response bundle of the divider: operand handshake in, result
// handshake out. The divider sits on the slave side.
interface divider_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_trial_sub.sv
// Trial subtractor for one restoring-division step: difference and borrow
// of a (WIDTH+1)-bit minuend minus a WIDTH-bit subtrahend.
module div_trial_sub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic [WIDTH:0]   difference,
  output logic             borrow
);

  logic [WIDTH+1:0] sum;

  // Two's-complement subtract; a carry out of the top bit means no borrow.
  assign sum        = {1'b0, minuend} + {1'b0, ~{1'b0, subtrahend}} + (WIDTH+2)'(1);
  assign difference = sum[WIDTH:0];
  assign borrow     = ~sum[WIDTH+1];

endmodule

// File: rtl/divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per cycle,
// valid/ready handshakes on both sides, divide-by-zero short cut.
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic     clk,
  input  logic     reset,
  divider_if.slave bus
);

  localparam int            CW        = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_e           state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem, dvd, divisor;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic             dbz_q;

  logic             accept;
  logic [WIDTH:0]   shifted, diff;
  logic             borrow;
  logic             diff_top_unused;
  logic [WIDTH-1:0] rem_step, dvd_step;

  assign accept = bus.in_valid && (state == IDLE);

  // {rem, dvd} shifted left by one; the dividend MSB enters the remainder.
  assign shifted = {rem, dvd[WIDTH-1]};

  div_trial_sub #(.WIDTH(WIDTH)) u_trial_sub (
    .minuend    (shifted),
    .subtrahend (divisor),
    .difference (diff),
    .borrow     (borrow)
  );

  // rem < divisor always holds, so a committed difference never reaches bit WIDTH.
  assign diff_top_unused = diff[WIDTH];
  assign rem_step        = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign dvd_step        = {dvd[WIDTH-2:0], ~borrow};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: state_next gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = (bus.B == '0) ? DONE : BUSY;
      BUSY:    if (count == LAST_STEP) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      rem         <= '0;
      dvd         <= '0;
      divisor     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else if (accept) begin
      count   <= '0;
      rem     <= '0;
      dvd     <= bus.A;
      divisor <= bus.B;
      dbz_q   <= (bus.B == '0);
      if (bus.B == '0) begin
        quotient_q  <= '1;
        remainder_q <= bus.A;
      end
    end else if (state == BUSY) begin
      count <= count + CW'(1);
      rem   <= rem_step;
      dvd   <= dvd_step;
      if (count == LAST_STEP) begin
        quotient_q  <= dvd_step;
        remainder_q <= rem_step;
      end
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed operations with literal
// expectations plus a per-cycle comparison against an arithmetic model.
module tb_divider;

  localparam int W = 32;

  typedef enum {M_IDLE, M_BUSY, M_DONE} mphase_e;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   armed    = 1'b0;

  divider_if #(.WIDTH(W)) bus ();

  divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Model: result from plain / and %, presented after a fixed latency.
  mphase_e        m_phase = M_IDLE;
  int             m_left  = 0;
  logic [W-1:0]   m_q     = '0;
  logic [W-1:0]   m_r     = '0;
  logic           m_dbz   = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase <= M_IDLE;
      m_dbz   <= 1'b0;
    end else begin
      case (m_phase)
        M_IDLE: if (bus.in_valid) begin
          if (bus.B == '0) begin
            m_q     <= '1;
            m_r     <= bus.A;
            m_dbz   <= 1'b1;
            m_phase <= M_DONE;
          end else begin
            m_q     <= bus.A / bus.B;
            m_r     <= bus.A % bus.B;
            m_dbz   <= 1'b0;
            m_left  <= W;
            m_phase <= M_BUSY;
          end
        end
        M_BUSY: begin
          m_left <= m_left - 1;
          if (m_left == 1) m_phase <= M_DONE;
        end
        M_DONE: if (bus.out_ready) m_phase <= M_IDLE;
        default: m_phase <= M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("cyc_in_ready", 64'(bus.in_ready), 64'(m_phase == M_IDLE));
      check("cyc_out_valid", 64'(bus.out_valid), 64'(m_phase == M_DONE));
      check("cyc_div_by_zero", 64'(bus.div_by_zero), 64'(m_dbz));
      if (m_phase == M_DONE) begin
        check("cyc_quotient", 64'(bus.quotient), 64'(m_q));
        check("cyc_remainder", 64'(bus.remainder), 64'(m_r));
      end
    end
  end

  // Called #1 after a rising edge with the DUT idle. elat counts edges from
  // the accept edge (inclusive) to the edge that raises out_valid.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit early_ready, input int hold,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic ed, input int elat);
    int lat;
    bus.A         = a;
    bus.B         = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = early_ready;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(elat));
    check("quotient", 64'(bus.quotient), 64'(eq));
    check("remainder", 64'(bus.remainder), 64'(er));
    check("div_by_zero", 64'(bus.div_by_zero), 64'(ed));
    check("model_quotient", 64'(m_q), 64'(eq));
    check("model_remainder", 64'(m_r), 64'(er));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.A        = ~a;
      bus.B        = b + 1;
      @(posedge clk); #1;
      check("hold_quotient", 64'(bus.quotient), 64'(eq));
      check("hold_remainder", 64'(bus.remainder), 64'(er));
      check("hold_div_by_zero", 64'(bus.div_by_zero), 64'(ed));
      check("hold_out_valid", 64'(bus.out_valid), 64'(1));
      check("hold_in_ready", 64'(bus.in_ready), 64'(0));
    end
    // in_valid stays high across the consume edge when holding: no accept there.
    bus.in_valid  = (hold > 0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("consume_in_ready", 64'(bus.in_ready), 64'(1));
    check("consume_out_valid", 64'(bus.out_valid), 64'(0));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    armed = 1'b1;
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_quotient", 64'(bus.quotient), 64'(0));
    check("rst_remainder", 64'(bus.remainder), 64'(0));
    check("rst_div_by_zero", 64'(bus.div_by_zero), 64'(0));

    run_op(32'd100, 32'd7, 1'b1, 0, 32'd14, 32'd2, 1'b0, W + 1);
    run_op(32'd5, 32'd0, 1'b1, 0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
    run_op(32'd3, 32'd10, 1'b0, 0, 32'd0, 32'd3, 1'b0, W + 1);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b1, 0, 32'hFFFF_FFFF, 32'd0, 1'b0, W + 1);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 32'd1, 32'd0, 1'b0, W + 1);
    run_op(32'd77, 32'd77, 1'b0, 0, 32'd1, 32'd0, 1'b0, W + 1);
    run_op(32'd0, 32'd0, 1'b0, 5, 32'hFFFF_FFFF, 32'd0, 1'b1, 1);
    run_op(32'd1000, 32'd3, 1'b0, 5, 32'd333, 32'd1, 1'b0, W + 1);
    run_op(32'hDEAD_BEEF, 32'h0001_0000, 1'b0, 0, 32'h0000_DEAD, 32'h0000_BEEF, 1'b0, W + 1);

    // Abort an operation at BUSY step 10.
    bus.A        = 32'd1000;
    bus.B        = 32'd3;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_in_ready", 64'(bus.in_ready), 64'(1));
    check("abort_out_valid", 64'(bus.out_valid), 64'(0));
    check("abort_quotient", 64'(bus.quotient), 64'(0));
    check("abort_remainder", 64'(bus.remainder), 64'(0));
    check("abort_div_by_zero", 64'(bus.div_by_zero), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_result", 64'(bus.out_valid), 64'(0));
    run_op(32'd9, 32'd3, 1'b0, 0, 32'd3, 32'd0, 1'b0, W + 1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  request carries valid operands.
REQ-005 SHALL have port: in_ready  output  1  block can accept a request.
REQ-006 SHALL have port: A  input  WIDTH  unsigned dividend.
REQ-007 SHALL have port: B  input  WIDTH  unsigned divisor.
REQ-008 SHALL have port: out_valid  output  1  quotient/remainder valid.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port: quotient  output  WIDTH  A / B.
REQ-011 SHALL have port: remainder  output  WIDTH  A mod B.
REQ-012 SHALL have port: div_by_zero  output  1  result produced with B == 0.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-014 SHALL accept a request on an edge where in_valid && in_ready, latching A and B; in_valid outside IDLE is ignored with no side effect.
REQ-015 SHALL, on accept with B != 0, enter BUSY with iteration counter 0, partial remainder 0, dividend shift register = A.
REQ-016 SHALL perform one restoring-division step per BUSY cycle: shift {rem, dividend} left 1; trial-subtract B from the (WIDTH+1)-bit shifted remainder; no borrow -> commit difference and shift in quotient bit 1, else keep remainder and shift in 0.
REQ-017 SHALL leave BUSY for DONE after exactly WIDTH steps; out_valid first high WIDTH+1 edges after the accept edge.
REQ-018 SHALL, on accept with B == 0, go directly to DONE (out_valid high 1 edge after accept) with quotient = all ones, remainder = A, div_by_zero = 1.
REQ-019 SHALL hold quotient, remainder, div_by_zero stable while in DONE and out_ready is low, for any number of cycles.
REQ-020 SHALL return to IDLE on an edge where out_valid && out_ready; a new request cannot be accepted on that same edge.
REQ-021 SHALL clear div_by_zero on every non-zero-divisor accept; quotient/remainder are registered outputs, not combinational from the datapath.
REQ-022 SHALL produce exact results for all operand values, including A < B (q=0, r=A), A == B (q=1, r=0), B == 1, and A = B = 2^WIDTH-1.

Reset
REQ-023 SHALL, when reset is high at a rising edge, force state IDLE, counter 0, quotient 0, remainder 0, div_by_zero 0, out_valid 0, in_ready 1, overriding any other event that cycle.
REQ-024 SHALL abort an in-progress BUSY or DONE operation on reset, discarding it with no result ever presented.

Structure
REQ-025 SHALL place the FSM state encoding (IDLE/BUSY/DONE) and the default WIDTH constant in a shared ALU package.
REQ-026 SHALL isolate the trial subtractor as sub-module div_trial_sub: (WIDTH+1)-bit minuend, WIDTH-bit subtrahend, difference and borrow out, computed as minuend + ~subtrahend + 1.
REQ-027 SHALL size the iteration counter as clog2(WIDTH)+1 bits.

Verification
REQ-028 SHALL cover: A=100, B=7, out_ready=1 -> out_valid 33 edges after accept, quotient=14, remainder=2, div_by_zero=0.
REQ-029 SHALL cover: A=5, B=0 -> out_valid 1 edge after accept, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1.
REQ-030 SHALL cover: A=3, B=10 -> q=0, r=3; A=0xFFFFFFFF, B=1 -> q=0xFFFFFFFF, r=0; A=B=0xFFFFFFFF -> q=1, r=0.
REQ-031 SHALL cover: out_ready low 5 cycles after out_valid -> outputs unchanged, in_ready 0, second in_valid ignored; out_ready high -> IDLE next edge.
REQ-032 SHALL cover: reset asserted at BUSY step 10 -> next cycle all outputs 0, in_ready 1; subsequent A=9, B=3 -> q=3, r=0 at normal latency.
